// File: rtl/fixed_p_div_pkg.sv
// fixed_p_div_pkg: shared FSM state type and counter sizing for the fixed-point divider.
package fixed_p_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
  function automatic int cnt_w(input int w, input int f);
    return $clog2(w + f + 1);
  endfunction
endpackage

// File: rtl/fixed_p_div_step.sv
// fixed_p_div_step: one combinational restoring-division iteration, MSB first.
module fixed_p_div_step #(
  parameter int width = 32
) (
  input  logic [width:0]   rem_i,
  input  logic [width-1:0] divisor_i,
  input  logic             bit_i,
  output logic [width:0]   rem_o,
  output logic             q_o
);
  logic [width+1:0] sh;
  assign sh = {rem_i, bit_i};
  assign q_o = sh >= {2'b00, divisor_i};
  assign rem_o = (width+1)'(q_o ? sh - {2'b00, divisor_i} : sh);
endmodule

// File: rtl/fixed_p_std_div_pipe.sv
// fixed_p_std_div_pipe: sequential Q(int.fract) divider, (left << fract_width) / right, go/done handshake.
// Define FIXED_P_DIV_SATURATE_EN to saturate the quotient to all-ones on overflow.
module fixed_p_std_div_pipe
  import fixed_p_div_pkg::*;
#(
  parameter int width       = 32,
  parameter int int_width   = 8,
  parameter int fract_width = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  output logic [width-1:0] out_quotient,
  output logic [width-1:0] out_remainder,
  output logic             done
);
  localparam int K  = width + fract_width;
  localparam int CW = cnt_w(width, fract_width);
`ifdef FIXED_P_DIV_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  if (int_width + fract_width != width) begin : g_cfg_err
    $error("fixed_p_std_div_pipe: int_width + fract_width must equal width");
  end
  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [K-1:0]     dvd_q, dvd_d, quot_q, quot_d, full;
  logic [width-1:0] dvs_q, dvs_d, left_q, left_d, oq_q, oq_d, or_q, or_d;
  logic [width:0]   rem_q, rem_d, rem_n;
  logic             dz_q, dz_d, q_bit, ov;
  fixed_p_div_step #(.width(width)) u_step (
    .rem_i    (rem_q),
    .divisor_i(dvs_q),
    .bit_i    (dvd_q[K-1]),
    .rem_o    (rem_n),
    .q_o      (q_bit)
  );
  assign full = K'({quot_q, q_bit});
  assign ov = |full[K-1:width];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    left_d  = left_q;
    dz_d    = dz_q;
    rem_d   = rem_q;
    oq_d    = oq_q;
    or_d    = or_q;
    unique case (state_q)
      IDLE: if (go) begin
        state_d = RUN;
        dvd_d   = {left, {fract_width{1'b0}}};
        dvs_d   = right;
        left_d  = left;
        dz_d    = right == '0;
        rem_d   = '0;
        quot_d  = '0;
        cnt_d   = CW'(K);
      end
      RUN: begin
        rem_d  = rem_n;
        quot_d = full;
        dvd_d  = dvd_q << 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          oq_d    = (dz_q || (SAT && ov)) ? '1 : full[width-1:0];
          or_d    = dz_q ? left_q : rem_n[width-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      left_q  <= '0;
      dz_q    <= 1'b0;
      rem_q   <= '0;
      oq_q    <= '0;
      or_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      left_q  <= left_d;
      dz_q    <= dz_d;
      rem_q   <= rem_d;
      oq_q    <= oq_d;
      or_q    <= or_d;
    end
  end
  assign out_quotient  = oq_q;
  assign out_remainder = or_q;
  assign done          = state_q == DONE;
endmodule

// File: tb/tb_fixed_p_std_div_pipe.sv
// tb_fixed_p_std_div_pipe: directed bench with a result scoreboard for the Q4.4 divider.
module tb_fixed_p_std_div_pipe;
  localparam int W = 8;
  localparam int F = 4;
`ifdef FIXED_P_DIV_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;
  logic clk = 1'b0;
  logic reset, go, done;
  logic [W-1:0] left, right, oq, orr;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, d0;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fixed_p_std_div_pipe #(.width(W), .int_width(4), .fract_width(F)) dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .left         (left),
    .right        (right),
    .out_quotient (oq),
    .out_remainder(orr),
    .done         (done)
  );
  function automatic exp_t model(input logic [W-1:0] l, input logic [W-1:0] r);
    logic [W+F-1:0] n, full;
    exp_t e;
    n = {l, {F{1'b0}}};
    if (r == '0) begin
      e.q = '1;
      e.r = l;
    end else begin
      full = n / r;
      e.r  = W'(n % r);
      e.q  = (SAT && |full[W+F-1:W]) ? '1 : full[W-1:0];
    end
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [W-1:0] l, input logic [W-1:0] r, input bit hold);
    go = 1'b1;
    left = l;
    right = r;
    sb.push_back(model(l, r));
    @(negedge clk);
    if (!hold) go = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int lat, input bit toggle);
    int n = 1;
    while (!done && n < 40) begin
      if (toggle) begin
        go    = (n < 10) ? 1'($urandom) : 1'b0;
        left  = W'($urandom);
        right = W'($urandom);
      end
      @(negedge clk);
      n++;
    end
    chk(tag, n, lat);
  endtask
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        chk("quotient", oq, sb[0].q);
        chk("remainder", orr, sb[0].r);
        void'(sb.pop_front());
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    reset = 1'b1;
    go = 1'b0;
    left = '0;
    right = '0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", oq, 0);
    chk("rst_remainder", orr, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);
    start(8'h30, 8'h20, 0);
    wait_done("lat_basic", 13, 0);
    @(negedge clk);
    start(8'h10, 8'h30, 0);
    wait_done("lat_remainder", 13, 0);
    @(negedge clk);
    start(8'hF0, 8'h01, 0);
    wait_done("lat_overflow", 13, 0);
    @(negedge clk);
    d0 = done_cnt;
    start(8'h25, 8'h00, 0);
    wait_done("lat_div0", 13, 1);
    repeat (20) @(negedge clk);
    chk("div0_done_once", done_cnt - d0, 1);
    d0 = done_cnt;
    start(8'h30, 8'h20, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_quotient", oq, 0);
    chk("abort_remainder", orr, 0);
    start(8'h30, 8'h20, 0);
    wait_done("lat_restart", 13, 0);
    @(negedge clk);
    start(8'h30, 8'h20, 1);
    left = 8'h10;
    right = 8'h30;
    sb.push_back(model(8'h10, 8'h30));
    wait_done("lat_b2b_first", 13, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) go = 1'b0;
    end while (!done && n < 40);
    chk("b2b_gap", n, 14);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start(W'($urandom), W'($urandom), 0);
      wait_done("lat_random", 13, 0);
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
